// File: rtl/common.sv
// Shared definitions for the pipeline hazard controller.
// Holds the hazard FSM state type, register-index width, datapath width
// and the source/destination match helper used by hazard detection.
package common;

  localparam int unsigned REGISTER_WIDTH = 32;
  localparam int unsigned REG_IDX_W      = 5;
  localparam int unsigned STALL_CNT_W    = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } hazard_state_t;

  // True when an instruction actually reads source register src and it equals dst.
  function automatic logic src_matches(input logic                 uses,
                                       input logic [REG_IDX_W-1:0] src,
                                       input logic [REG_IDX_W-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/saturating_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high clear
//   inc   - count enable for this cycle
//   count - current value; sticks at all-ones
module saturating_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Increment unless already at the all-ones ceiling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode/execute hazard controller for an in-order pipeline.
// Handles taken-branch flush (plus one redirect cycle), one-cycle load-use
// stalls with bubble insertion, and stalling while a multi-cycle MUL/DIV runs.
// Ports:
//   clk, reset                      - clock, async active-high reset
//   id_*                            - decode-stage instruction description
//   ex_branch_taken                 - execute-stage branch resolution
//   mc_done                         - multi-cycle unit result pulse
//   stall_fetch/stall_decode        - combinational hold of fetch/decode
//   flush_decode                    - combinational decode invalidate
//   ex_valid/ex_rd/ex_is_load       - registered execute-stage state
//   mc_start                        - registered start pulse to multi-cycle unit
//   stall_cycles                    - saturating count of stall_decode cycles
module pipeline_hazard_controller
  import common::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_IDX_W-1:0]   id_rd,
  input  logic                   id_is_load,
  input  logic                   id_is_multicycle,
  input  logic                   ex_branch_taken,
  input  logic                   mc_done,
  output logic                   stall_fetch,
  output logic                   stall_decode,
  output logic                   flush_decode,
  output logic                   ex_valid,
  output logic [REG_IDX_W-1:0]   ex_rd,
  output logic                   ex_is_load,
  output logic                   mc_start,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  hazard_state_t          state;
  hazard_state_t          state_nxt;
  logic                   ex_valid_nxt;
  logic [REG_IDX_W-1:0]   ex_rd_nxt;
  logic                   ex_is_load_nxt;
  logic                   mc_start_nxt;
  logic                   stall;
  logic                   flush;
  logic                   load_use;
  logic                   do_issue;

  // Load in execute whose nonzero destination is read by the decode instruction.
  assign load_use = ex_valid && ex_is_load && (ex_rd != '0) && id_valid &&
                    (src_matches(id_uses_rs1, id_rs1, ex_rd) ||
                     src_matches(id_uses_rs2, id_rs2, ex_rd));

  // Next-state and combinational stall/flush decode.
  always_comb begin
    state_nxt      = state;
    ex_valid_nxt   = ex_valid;
    ex_rd_nxt      = ex_rd;
    ex_is_load_nxt = ex_is_load;
    mc_start_nxt   = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    do_issue       = 1'b0;

    case (state)
      RUN: begin
        if (ex_valid && ex_branch_taken) begin
          flush          = 1'b1;
          ex_valid_nxt   = 1'b0;
          ex_rd_nxt      = '0;
          ex_is_load_nxt = 1'b0;
          state_nxt      = REDIRECT;
        end else begin
          do_issue = 1'b1;
        end
      end
      MC_WAIT: begin
        // Execute contents hold until the unit reports done.
        if (mc_done) begin
          do_issue = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      REDIRECT: begin
        flush          = 1'b1;
        ex_valid_nxt   = 1'b0;
        ex_rd_nxt      = '0;
        ex_is_load_nxt = 1'b0;
        state_nxt      = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    // Shared issue path: bubble on load-use, otherwise advance decode.
    if (do_issue) begin
      if (load_use) begin
        stall          = 1'b1;
        ex_valid_nxt   = 1'b0;
        ex_rd_nxt      = '0;
        ex_is_load_nxt = 1'b0;
        state_nxt      = RUN;
      end else begin
        ex_valid_nxt   = id_valid;
        ex_rd_nxt      = id_valid ? id_rd : '0;
        ex_is_load_nxt = id_valid && id_is_load;
        if (id_valid && id_is_multicycle) begin
          state_nxt    = MC_WAIT;
          mc_start_nxt = 1'b1;
        end else begin
          state_nxt    = RUN;
        end
      end
    end
  end

  assign stall_fetch  = stall;
  assign stall_decode = stall;
  assign flush_decode = flush;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_is_load <= 1'b0;
      mc_start   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ex_valid   <= ex_valid_nxt;
      ex_rd      <= ex_rd_nxt;
      ex_is_load <= ex_is_load_nxt;
      mc_start   <= mc_start_nxt;
    end
  end

  saturating_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic        id_is_multicycle;
  logic        ex_branch_taken;
  logic        mc_done;
  logic        stall_fetch;
  logic        stall_decode;
  logic        flush_decode;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        mc_start;
  logic [31:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_controller dut (
    .clk              (clk),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .id_rd            (id_rd),
    .id_is_load       (id_is_load),
    .id_is_multicycle (id_is_multicycle),
    .ex_branch_taken  (ex_branch_taken),
    .mc_done          (mc_done),
    .stall_fetch      (stall_fetch),
    .stall_decode     (stall_decode),
    .flush_decode     (flush_decode),
    .ex_valid         (ex_valid),
    .ex_rd            (ex_rd),
    .ex_is_load       (ex_is_load),
    .mc_start         (mc_start),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic ld, input logic mc);
    id_valid         = v;
    id_rs1           = rs1;
    id_uses_rs1      = u1;
    id_rs2           = rs2;
    id_uses_rs2      = u2;
    id_rd            = rd;
    id_is_load       = ld;
    id_is_multicycle = mc;
  endtask

  task automatic idle_id();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    ex_branch_taken = 1'b0;
    mc_done         = 1'b0;
    idle_id();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    check("rst_mc_start", 32'(mc_start), 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    check("rst_stall", 32'(stall_decode), 32'd0);
    reset = 1'b0;

    // Load x5 then add reading x5: one stall, bubble, add issues next
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    #1;
    check("lu_load_no_stall", 32'(stall_decode), 32'd0);
    tick();
    check("lu_ex_load_rd", 32'(ex_rd), 32'd5);
    check("lu_ex_is_load", 32'(ex_is_load), 32'd1);
    drive_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0);
    #1;
    check("lu_stall_decode", 32'(stall_decode), 32'd1);
    check("lu_stall_fetch", 32'(stall_fetch), 32'd1);
    check("lu_no_flush", 32'(flush_decode), 32'd0);
    tick();
    #1;
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_one_cycle", 32'(stall_decode), 32'd0);
    check("lu_count", stall_cycles, 32'd1);
    tick();
    check("lu_add_issued", 32'(ex_valid), 32'd1);
    check("lu_add_rd", 32'(ex_rd), 32'd6);
    check("lu_add_not_load", 32'(ex_is_load), 32'd0);

    // Load-use through rs2 only
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
    #1;
    check("lu_rs2_stall", 32'(stall_decode), 32'd1);
    tick();
    tick();
    check("lu_rs2_issued_rd", 32'(ex_rd), 32'd4);
    check("lu_rs2_count", stall_cycles, 32'd2);

    // Load x0 then read x0: no stall; unused source does not match
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    #1;
    check("x0_no_stall", 32'(stall_decode), 32'd0);
    tick();
    check("x0_issued_rd", 32'(ex_rd), 32'd7);
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd8, 1'b0, 5'd8, 1'b0, 5'd2, 1'b0, 1'b0);
    #1;
    check("unused_src_no_stall", 32'(stall_decode), 32'd0);
    tick();
    check("unused_src_issued", 32'(ex_rd), 32'd2);

    // Taken branch with load-use match in decode: flush wins, 2 flush cycles
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    check("br_flush1", 32'(flush_decode), 32'd1);
    check("br_no_stall1", 32'(stall_decode), 32'd0);
    tick();
    #1;
    check("br_flush2", 32'(flush_decode), 32'd1);
    check("br_no_stall2", 32'(stall_decode), 32'd0);
    check("br_ex_valid1", 32'(ex_valid), 32'd0);
    tick();
    ex_branch_taken = 1'b0;
    idle_id();
    #1;
    check("br_ex_valid2", 32'(ex_valid), 32'd0);
    check("br_flush_done", 32'(flush_decode), 32'd0);
    check("br_count", stall_cycles, 32'd2);
    tick();

    // MUL with mc_done after four stalled cycles
    drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b1);
    #1;
    check("mc_issue_no_stall", 32'(stall_decode), 32'd0);
    tick();
    drive_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mc_start_pulse", 32'(mc_start), (i == 0) ? 32'd1 : 32'd0);
      check("mc_wait_stall", 32'(stall_decode), 32'd1);
      check("mc_ex_rd_hold", 32'(ex_rd), 32'd9);
      tick();
    end
    mc_done = 1'b1;
    #1;
    check("mc_done_no_stall", 32'(stall_decode), 32'd0);
    tick();
    mc_done = 1'b0;
    idle_id();
    check("mc_next_issued", 32'(ex_rd), 32'd10);
    check("mc_start_low", 32'(mc_start), 32'd0);
    check("mc_count", stall_cycles, 32'd6);
    tick();

    // Reset during MC_WAIT, then a stray mc_done
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b0, 1'b1);
    tick();
    idle_id();
    #1;
    check("rmc_stall_before", 32'(stall_decode), 32'd1);
    reset = 1'b1;
    #1;
    check("rmc_ex_valid", 32'(ex_valid), 32'd0);
    check("rmc_mc_start", 32'(mc_start), 32'd0);
    check("rmc_count", stall_cycles, 32'd0);
    check("rmc_no_stall", 32'(stall_decode), 32'd0);
    tick();
    reset   = 1'b0;
    mc_done = 1'b1;
    #1;
    check("rmc_done_no_stall", 32'(stall_decode), 32'd0);
    tick();
    mc_done = 1'b0;
    check("rmc_done_ex_valid", 32'(ex_valid), 32'd0);
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b0, 1'b0);
    #1;
    check("rmc_run_no_stall", 32'(stall_decode), 32'd0);
    tick();
    idle_id();
    check("rmc_run_issue", 32'(ex_rd), 32'd12);

    // Saturation of stall_cycles
    force dut.u_stall_ctr.count = 32'hFFFF_FFFE;
    tick();
    release dut.u_stall_ctr.count;
    #1;
    check("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b0, 1'b1);
    tick();
    idle_id();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sat_stall", 32'(stall_decode), 32'd1);
      tick();
      check("sat_value", stall_cycles, 32'hFFFF_FFFF);
    end
    mc_done = 1'b1;
    #1;
    check("sat_done_no_stall", 32'(stall_decode), 32'd0);
    tick();
    mc_done = 1'b0;
    check("sat_hold", stall_cycles, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
